// File: rtl/calc_pkg.sv
// Shared calculator types: output code space, digit width and formatter state encodings.
package calc_pkg;

  localparam int unsigned DIGIT_W = 4;
  localparam int unsigned CODE_W  = 8;

  typedef logic [CODE_W-1:0] code_t;

  localparam code_t HASH_CODE  = 8'd10;
  localparam code_t MINUS_CODE = 8'd21;

  typedef enum logic [2:0] {
    IDLE,
    CONV_H,
    CONV_T,
    EMIT,
    TERM
  } fmt_state_t;

  // Which field of the formatted result is currently on out_data.
  typedef enum logic [1:0] {
    SEL_MINUS,
    SEL_H,
    SEL_T,
    SEL_ONES
  } emit_sel_t;

endpackage

// File: rtl/result_bcd_split.sv
// Repeated-subtraction splitter: hundreds while conv_h, tens while conv_t; the remainder is the ones digit.
module result_bcd_split
  import calc_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [7:0]         value,
  input  logic               conv_h,
  input  logic               conv_t,
  output logic               hund_done_c,
  output logic               done_c,
  output logic [1:0]         h,
  output logic [DIGIT_W-1:0] t,
  output logic [DIGIT_W-1:0] ones
);

  logic [7:0] val;

  assign hund_done_c = (val < 8'd100);
  assign done_c      = conv_t && (val < 8'd10);
  // Once the tens phase finishes val is below 10, so its low nibble is the ones digit.
  assign ones        = val[DIGIT_W-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      val <= 8'd0;
      h   <= 2'd0;
      t   <= DIGIT_W'(0);
    end else if (start) begin
      val <= value;
      h   <= 2'd0;
      t   <= DIGIT_W'(0);
    end else if (conv_h && !hund_done_c) begin
      val <= val - 8'd100;
      h   <= h + 2'd1;
    end else if (conv_t && (val >= 8'd10)) begin
      val <= val - 8'd10;
      t   <= t + DIGIT_W'(1);
    end
  end

endmodule

// File: rtl/result_formatter.sv
// Formats an 8-bit result as decimal digit codes followed by a terminator.
// Optional RESULT_SIGNED_EN: treat in_data as two's complement and emit MINUS_CODE first.
module result_formatter
  import calc_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_data,
  output logic              out_last,
  output logic              busy
);

  fmt_state_t         state, state_d;
  emit_sel_t          sel, sel_d, lead_sel, step_sel, first_sel;
  logic               neg, neg_c, start;
  logic [7:0]         mag_c;
  logic               valid_d, last_d;
  code_t              data_d;
  logic               hund_done_c, done_c;
  logic [1:0]         h;
  logic [DIGIT_W-1:0] t, ones;

`ifdef RESULT_SIGNED_EN
  assign neg_c = in_data[DATA_W-1];
  assign mag_c = neg_c ? 8'(-in_data) : 8'(in_data);
`else
  assign neg_c = 1'b0;
  assign mag_c = 8'(in_data);
`endif

  result_bcd_split u_split (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .value      (mag_c),
    .conv_h     (state == CONV_H),
    .conv_t     (state == CONV_T),
    .hund_done_c(hund_done_c),
    .done_c     (done_c),
    .h          (h),
    .t          (t),
    .ones       (ones)
  );

  function automatic code_t sel_code(input emit_sel_t s, input logic [1:0] hd,
                                     input logic [DIGIT_W-1:0] td, input logic [DIGIT_W-1:0] od);
    case (s)
      SEL_MINUS: return MINUS_CODE;
      SEL_H:     return code_t'(hd);
      SEL_T:     return code_t'(td);
      default:   return code_t'(od);
    endcase
  endfunction

  // Leading-zero suppression: first nonzero of h/t, else straight to ones.
  always_comb begin
    lead_sel  = (h != 2'd0) ? SEL_H : ((t != DIGIT_W'(0)) ? SEL_T : SEL_ONES);
    first_sel = neg ? SEL_MINUS : lead_sel;
    case (sel)
      SEL_MINUS: step_sel = lead_sel;
      SEL_H:     step_sel = SEL_T;
      default:   step_sel = SEL_ONES;
    endcase
  end

  always_comb begin
    state_d = state;
    sel_d   = sel;
    valid_d = out_valid;
    data_d  = out_data;
    last_d  = out_last;
    start   = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          start   = 1'b1;
          state_d = CONV_H;
        end
      end
      CONV_H: begin
        if (hund_done_c) state_d = CONV_T;
      end
      CONV_T: begin
        if (done_c) begin
          state_d = EMIT;
          sel_d   = first_sel;
          valid_d = 1'b1;
          data_d  = sel_code(first_sel, h, t, ones);
          last_d  = 1'b0;
        end
      end
      EMIT: begin
        if (out_ready) begin
          if (sel == SEL_ONES) begin
            state_d = TERM;
            data_d  = HASH_CODE;
            last_d  = 1'b1;
          end else begin
            sel_d  = step_sel;
            data_d = sel_code(step_sel, h, t, ones);
          end
        end
      end
      TERM: begin
        if (out_ready) begin
          state_d = IDLE;
          valid_d = 1'b0;
          data_d  = '0;
          last_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      sel       <= SEL_MINUS;
      neg       <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      in_ready  <= 1'b1;
      busy      <= 1'b0;
    end else begin
      state     <= state_d;
      sel       <= sel_d;
      out_valid <= valid_d;
      out_data  <= data_d;
      out_last  <= last_d;
      in_ready  <= (state_d == IDLE);
      busy      <= (state_d != IDLE);
      if (start) neg <= neg_c;
    end
  end

endmodule

// File: tb/tb_result_formatter.sv
// Scoreboard bench for result_formatter; expected code streams come from a divide/modulo model.
module tb_result_formatter;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_last;
  logic       busy;

  int vectors = 0;
  int miscompares = 0;
  logic [8:0] exp_q[$];

  always #5 clk = ~clk;

  result_formatter #(.DATA_W(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_last (out_last),
    .busy     (busy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pushes {last, code} entries for v and returns the expected first-code latency.
  task automatic model(input logic [7:0] v, output int lat);
    int m, hd, td, od;
    bit ng;
    ng = 1'b0;
    m  = int'(v);
`ifdef RESULT_SIGNED_EN
    if (v[7]) begin
      ng = 1'b1;
      m  = 256 - int'(v);
    end
`endif
    hd = m / 100;
    td = (m / 10) % 10;
    od = m % 10;
    if (ng) exp_q.push_back(9'd21);
    if (hd != 0) exp_q.push_back(9'(hd));
    if (hd != 0 || td != 0) exp_q.push_back(9'(td));
    exp_q.push_back(9'(od));
    exp_q.push_back({1'b1, 8'd10});
    lat = hd + td + 2;
  endtask

  task automatic send(input logic [7:0] v, output int lat);
    int g;
    model(v, lat);
    in_data  = v;
    in_valid = 1'b1;
    g = 0;
    while (in_ready !== 1'b1 && g < 50) begin step(); g++; end
    step();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_data = 8'd0; out_ready = 1'b0;
    #2;
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    vectors++; if (out_data !== 8'd0) begin miscompares++; $display("FAIL reset_out_data: got %0d expected 0", out_data); end
    vectors++; if (out_last !== 1'b0) begin miscompares++; $display("FAIL reset_out_last: got %b expected 0", out_last); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", busy); end
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    @(negedge clk);
    rst = 1'b0;
    step();
  endtask

  task automatic test_zero();
    int lat, n, g;
    logic [8:0] e;
    send(8'd0, lat);
    n = 0;
    while (out_valid !== 1'b1 && n < 40) begin step(); n++; end
    vectors++; if (n != lat) begin miscompares++; $display("FAIL zero_latency: got %0d clocks expected %0d", n, lat); end
    g = 0;
    while (exp_q.size() != 0 && g < 60) begin
      out_ready = 1'b1;
      if (out_valid === 1'b1) begin
        e = exp_q.pop_front(); vectors++;
        if ({out_last, out_data} !== e) begin miscompares++; $display("FAIL zero_stream: got last=%0b code=%0d expected last=%0b code=%0d", out_last, out_data, e[8], e[7:0]); end
      end
      step(); g++;
    end
    out_ready = 1'b0;
    vectors++; if (exp_q.size() != 0) begin miscompares++; $display("FAIL zero_timeout: got %0d codes left expected 0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_max();
    int lat, n, g;
    logic [8:0] e;
    send(8'd255, lat);
    out_ready = 1'b1;
    n = 0;
    while (out_valid !== 1'b1 && n < 40) begin step(); n++; end
    vectors++; if (n != lat) begin miscompares++; $display("FAIL max_latency: got %0d clocks expected %0d", n, lat); end
    g = 0;
    while (exp_q.size() != 0 && g < 60) begin
      e = exp_q.pop_front(); vectors++;
      if (out_valid !== 1'b1 || {out_last, out_data} !== e) begin
        miscompares++;
        $display("FAIL max_stream: got valid=%0b last=%0b code=%0d expected valid=1 last=%0b code=%0d", out_valid, out_last, out_data, e[8], e[7:0]);
      end
      step(); g++;
    end
    out_ready = 1'b0;
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL max_after_term: got valid=%0b expected 0", out_valid); end
  endtask

  task automatic test_stall();
    int lat, n, g;
    logic [8:0] e;
    send(8'd107, lat);
    n = 0;
    while (out_valid !== 1'b1 && n < 40) begin step(); n++; end
    vectors++; if (n != lat) begin miscompares++; $display("FAIL stall_latency: got %0d clocks expected %0d", n, lat); end
    out_ready = 1'b1;
    e = exp_q.pop_front(); vectors++;
    if ({out_last, out_data} !== e) begin miscompares++; $display("FAIL stall_first: got code=%0d expected %0d", out_data, e[7:0]); end
    step();
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      vectors++;
      if (out_valid !== 1'b1 || out_data !== 8'd0 || out_last !== 1'b0) begin
        miscompares++;
        $display("FAIL stall_hold: got valid=%0b code=%0d last=%0b expected valid=1 code=0 last=0", out_valid, out_data, out_last);
      end
      step();
    end
    g = 0;
    while (exp_q.size() != 0 && g < 60) begin
      out_ready = 1'b1;
      if (out_valid === 1'b1) begin
        e = exp_q.pop_front(); vectors++;
        if ({out_last, out_data} !== e) begin miscompares++; $display("FAIL stall_stream: got last=%0b code=%0d expected last=%0b code=%0d", out_last, out_data, e[8], e[7:0]); end
      end
      step(); g++;
    end
    out_ready = 1'b0;
    vectors++; if (exp_q.size() != 0) begin miscompares++; $display("FAIL stall_timeout: got %0d codes left expected 0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_signed();
    logic [7:0] vals [3];
    int lat, n, g;
    logic [8:0] e;
    vals[0] = 8'hF6; vals[1] = 8'h80; vals[2] = 8'h05;
    for (int i = 0; i < 3; i++) begin
      send(vals[i], lat);
      n = 0;
      while (out_valid !== 1'b1 && n < 40) begin step(); n++; end
      vectors++; if (n != lat) begin miscompares++; $display("FAIL signed_latency: in=%0h got %0d clocks expected %0d", vals[i], n, lat); end
      g = 0;
      while (exp_q.size() != 0 && g < 60) begin
        out_ready = ($urandom_range(0, 2) != 0);
        if (out_valid === 1'b1 && out_ready) begin
          e = exp_q.pop_front(); vectors++;
          if ({out_last, out_data} !== e) begin miscompares++; $display("FAIL signed_stream: in=%0h got last=%0b code=%0d expected last=%0b code=%0d", vals[i], out_last, out_data, e[8], e[7:0]); end
        end
        step(); g++;
      end
      out_ready = 1'b0;
      vectors++; if (exp_q.size() != 0) begin miscompares++; $display("FAIL signed_timeout: in=%0h got %0d codes left expected 0", vals[i], exp_q.size()); exp_q.delete(); end
    end
  endtask

  task automatic test_ignore_and_reset();
    int lat, n, g;
    logic [8:0] e;
    send(8'd42, lat);
    n = 0;
    while (out_valid !== 1'b1 && n < 40) begin step(); n++; end
    in_valid = 1'b1; in_data = 8'd77;
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL ignore_in_ready: got %b expected 0", in_ready); end
    step();
    in_valid = 1'b0;
    g = 0;
    while (exp_q.size() != 0 && g < 60) begin
      out_ready = 1'b1;
      if (out_valid === 1'b1) begin
        e = exp_q.pop_front(); vectors++;
        if ({out_last, out_data} !== e) begin miscompares++; $display("FAIL ignore_stream: got last=%0b code=%0d expected last=%0b code=%0d", out_last, out_data, e[8], e[7:0]); end
      end
      step(); g++;
    end
    vectors++; if (exp_q.size() != 0) begin miscompares++; $display("FAIL ignore_timeout: got %0d codes left expected 0", exp_q.size()); exp_q.delete(); end
    for (int k = 0; k < 4; k++) begin
      vectors++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL ignore_no_extra: got valid=%0b busy=%0b expected 0 0", out_valid, busy); end
      step();
    end
    out_ready = 1'b0;
    send(8'd200, lat);
    exp_q.delete();
    n = 0;
    while (out_valid !== 1'b1 && n < 40) begin step(); n++; end
    out_ready = 1'b1;
    step();
    #2 rst = 1'b1;
    #1;
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL async_rst_valid: got %b expected 0", out_valid); end
    vectors++; if (in_ready !== 1'b1 || busy !== 1'b0) begin miscompares++; $display("FAIL async_rst_ready: got in_ready=%b busy=%b expected 1 0", in_ready, busy); end
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b0;
    step();
    send(8'd42, lat);
    g = 0;
    while (exp_q.size() != 0 && g < 60) begin
      out_ready = 1'b1;
      if (out_valid === 1'b1) begin
        e = exp_q.pop_front(); vectors++;
        if ({out_last, out_data} !== e) begin miscompares++; $display("FAIL post_rst_stream: got last=%0b code=%0d expected last=%0b code=%0d", out_last, out_data, e[8], e[7:0]); end
      end
      step(); g++;
    end
    out_ready = 1'b0;
    vectors++; if (exp_q.size() != 0) begin miscompares++; $display("FAIL post_rst_timeout: got %0d codes left expected 0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_back_to_back();
    int lat, n, g;
    logic [8:0] e;
    logic ir_at_term;
    ir_at_term = 1'bx;
    send(8'd9, lat);
    g = 0;
    while (exp_q.size() != 0 && g < 60) begin
      out_ready = 1'b1;
      if (out_valid === 1'b1) begin
        e = exp_q.pop_front(); vectors++;
        if ({out_last, out_data} !== e) begin miscompares++; $display("FAIL b2b_first_stream: got last=%0b code=%0d expected last=%0b code=%0d", out_last, out_data, e[8], e[7:0]); end
        if (exp_q.size() == 0) ir_at_term = in_ready;
      end
      step(); g++;
    end
    vectors++; if (exp_q.size() != 0) begin miscompares++; $display("FAIL b2b_timeout: got %0d codes left expected 0", exp_q.size()); exp_q.delete(); end
    vectors++; if (ir_at_term !== 1'b0) begin miscompares++; $display("FAIL b2b_ready_during_term: got %b expected 0", ir_at_term); end
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_ready_after_term: got %b expected 1", in_ready); end
    send(8'd100, lat);
    n = 0;
    while (out_valid !== 1'b1 && n < 40) begin step(); n++; end
    vectors++; if (n != lat) begin miscompares++; $display("FAIL b2b_latency: got %0d clocks expected %0d", n, lat); end
    g = 0;
    while (exp_q.size() != 0 && g < 60) begin
      if (out_valid === 1'b1) begin
        e = exp_q.pop_front(); vectors++;
        if ({out_last, out_data} !== e) begin miscompares++; $display("FAIL b2b_second_stream: got last=%0b code=%0d expected last=%0b code=%0d", out_last, out_data, e[8], e[7:0]); end
      end
      step(); g++;
    end
    out_ready = 1'b0;
    vectors++; if (exp_q.size() != 0) begin miscompares++; $display("FAIL b2b_second_timeout: got %0d codes left expected 0", exp_q.size()); exp_q.delete(); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_zero();
    test_max();
    test_stall();
    test_signed();
    test_ignore_and_reset();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/result_formatter.md
# result_formatter

Output-side counterpart of the calculator datapath's digit parser. Accepts an 8-bit evaluation result over a valid/ready handshake, splits it into decimal digits by sequential repeated subtraction, and streams one digit code per handshake in the same code space the expression ROM uses: digits 0–9 as raw values, terminator `#` = 10. Sits between the datapath result/operand-top output and the display or output buffer.

## Interface
Parameters:
- `DATA_W`, 8: result width; only 8 is supported.

Ports:
- `clk` input 1: single clock, rising edge.
- `rst` input 1: reset, asynchronous, active-high.
- `in_valid` input 1: `in_data` is valid.
- `in_ready` output 1: block can accept a result; high only in IDLE.
- `in_data` input 8: result to format.
- `out_valid` output 1: `out_data` holds a code.
- `out_ready` input 1: consumer takes the code.
- `out_data` output 8: digit code 0–9, `MINUS_CODE`, or `HASH_CODE`.
- `out_last` output 1: high with `HASH_CODE`.
- `busy` output 1: high in any state other than IDLE.

## Operation
- States: IDLE, CONV_H, CONV_T, EMIT, TERM.
- IDLE: `in_ready`=1. On `in_valid && in_ready`, latch the magnitude into `val`, clear `h`, `t` and `neg`, and go to CONV_H.
- CONV_H: each cycle, if `val >= 100`, then `val -= 100` and `h += 1`. Otherwise go to CONV_T.
- CONV_T: each cycle, if `val >= 10`, then `val -= 10` and `t += 1`. Otherwise the ones digit is `val`; go to EMIT.
- EMIT sequence, one code per handshake, in this order:
  - `MINUS_CODE`, only if `neg` is set.
  - `h`, only if `h != 0`.
  - `t`, if `h != 0` or `t != 0`.
  - ones, always.
  - Leading zeros are suppressed; the value 0 emits a single `0`.
- After the ones handshake, go to TERM: present `HASH_CODE` with `out_last`=1. On its handshake, return to IDLE.
- `out_valid` stays high from entry to EMIT until the TERM handshake. `out_data` and `out_last` are held stable while `out_valid && !out_ready`.
- `in_valid` outside IDLE is ignored; no queuing.
- Digit arithmetic: `h` is 2 bits wide (max 2), `t` is 4 bits wide (max 9). No overflow is possible for 8-bit inputs.

## Timing
- Reset values: `out_valid`=0, `out_data`=0, `out_last`=0, `busy`=0, `in_ready`=1. State is IDLE and all digit registers are 0.
- `rst` asserted in any state returns the block to IDLE immediately, without waiting for a clock edge. Any partially emitted stream is abandoned; the consumer sees `out_valid` drop without a terminator.
- Latency: `out_valid` rises `h + t + 2` clocks after the accepting edge. Examples: 0 → 2 clocks; 255 → 9 clocks.
- Each code occupies at least one cycle. With `out_ready` held high, one code is emitted per cycle.
- `in_ready` rises in the cycle after the TERM handshake, so back-to-back results have a one-cycle minimum gap.
- Simultaneous `out_ready` on the last digit and TERM entry: TERM is presented in the next cycle. `out_valid` does not drop in between.

## Configuration
- `RESULT_SIGNED_EN`:
  - Defined: `in_data` is two's complement. If bit 7 is set, `neg` is set and the magnitude is `-in_data`, computed combinationally at capture with no extra cycle. 0x80 formats as −128.
  - Undefined: `in_data` is unsigned 0–255, `neg` is tied to 0, and `MINUS_CODE` is never emitted.

## Structure
- Shared package `calc_pkg` holds:
  - `HASH_CODE` = 8'd10.
  - `MINUS_CODE` = 8'd21.
  - The digit-code type.
  - The `fmt_state_t` enum.
- One sub-module, `result_bcd_split`: the CONV_H/CONV_T repeated-subtraction engine. It has a start/done handshake and outputs `h`, `t` and ones.
- The top level owns the handshakes and the emit sequencer.

## Test plan
- Accept `in_data`=0 → `out_valid` 2 clocks later. Stream is 0, 10; `out_last` is high only on 10.
- Accept 255 (unsigned build) with `out_ready`=1 → first code 9 clocks after accept. Stream is 2, 5, 5, 10 on consecutive cycles.
- Accept 107; hold `out_ready`=0 for 3 cycles while `0` is presented → stream 1, 0, 7, 10, with `out_data` stable while stalled.
- `RESULT_SIGNED_EN` build:
  - 0xF6 → 21, 1, 0, 10.
  - 0x80 → 21, 1, 2, 8, 10.
  - 0x05 → 5, 10.
- Pulse `in_valid` with 77 during EMIT of 42 → ignored; stream stays 4, 2, 10. Then assert `rst` mid-stream of 200 → `out_valid`=0 and `in_ready`=1 without waiting for a clock edge. Next accept 42 → 4, 2, 10.
- Back-to-back 9 then 100 → 9, 10, then 1, 0, 0, 10. `in_ready` rises exactly one cycle after the first terminator handshake.
